// File: rtl/cache_pkg.sv
// cache_pkg: line-engine operation/state types and default line geometry
package cache_pkg;
  localparam int LINE_BYTES = 128;
  localparam int WORDS = LINE_BYTES / 4;
  localparam int WIDX_BITS = $clog2(WORDS);
  typedef enum logic {LINE_FILL, LINE_WB} line_op_e;
  typedef enum logic [2:0] {IDLE, RD, WB_REQ, WB_CAP, WR, DONE} state_e;
endpackage

// File: rtl/line_fill_engine_timer.sv
// mem_access_timer: counts the cycles of one fixed-latency memory access, flags its final cycle
module mem_access_timer #(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic last
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    last = run && (cnt_q == 8'(MEM_LATENCY - 1));
    cnt_d = (start || last) ? 8'd0 : run ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
endmodule

// File: rtl/line_fill_engine.sv
// line_fill_engine: turns a line fill or writeback into timed word accesses on the memory port
// CRITICAL_WORD_FIRST_EN: fills start at the requested word and wrap around the line
module line_fill_engine
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_SIZE  = LINE_BYTES,
  parameter int OFFSET_BITS = 7,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  fill_valid,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic [WIDX_BITS-1:0]  fill_word,
  output logic                  wb_req,
  output logic [WIDX_BITS-1:0]  wb_word,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  localparam logic [WIDX_BITS-1:0] LAST_W = WIDX_BITS'(BLOCK_SIZE / 4 - 1);
  localparam logic [WIDX_BITS-1:0] ONE_W = WIDX_BITS'(1);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] base_q, base_d;
  logic [WIDX_BITS-1:0] widx_q, widx_d, wcnt_q, wcnt_d, fill_word_q, fill_word_d, start_w;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d, mem_din_q, mem_din_d;
  logic fill_valid_q, fill_valid_d, accept, run, last, unused_lo;
  assign accept = req_valid && req_ready;
  assign run = state_q inside {RD, WR};
  assign unused_lo = ^req_addr[OFFSET_BITS-1:0];
`ifdef CRITICAL_WORD_FIRST_EN
  assign start_w = (line_op_e'(req_op) == LINE_FILL) ? req_addr[OFFSET_BITS-1:2] : '0;
`else
  assign start_w = '0;
`endif
  mem_access_timer #(.MEM_LATENCY(MEM_LATENCY)) u_timer (
    .clk(clk), .rst(rst), .start(accept), .run(run), .last(last)
  );
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    widx_d = widx_q;
    wcnt_d = wcnt_q;
    fill_valid_d = 1'b0;
    fill_data_d = fill_data_q;
    fill_word_d = fill_word_q;
    mem_din_d = mem_din_q;
    case (state_q)
      IDLE: if (accept) begin
        base_d = req_addr[ADDR_WIDTH-1:OFFSET_BITS];
        widx_d = start_w;
        wcnt_d = '0;
        state_d = (line_op_e'(req_op) == LINE_WB) ? WB_REQ : RD;
      end
      RD: if (last) begin
        fill_valid_d = 1'b1;
        fill_data_d = mem_dout;
        fill_word_d = widx_q;
        widx_d = widx_q + ONE_W;
        wcnt_d = wcnt_q + ONE_W;
        state_d = (wcnt_q == LAST_W) ? DONE : RD;
      end
      WB_REQ: state_d = WB_CAP;
      WB_CAP: begin
        mem_din_d = wb_data;
        state_d = WR;
      end
      WR: if (last) begin
        widx_d = widx_q + ONE_W;
        wcnt_d = wcnt_q + ONE_W;
        state_d = (wcnt_q == LAST_W) ? DONE : WB_REQ;
      end
      // a fill lingers here while its last fill_valid is out, so done follows it
      DONE: state_d = fill_valid_q ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      widx_q <= '0;
      wcnt_q <= '0;
      fill_valid_q <= 1'b0;
      fill_data_q <= '0;
      fill_word_q <= '0;
      mem_din_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      widx_q <= widx_d;
      wcnt_q <= wcnt_d;
      fill_valid_q <= fill_valid_d;
      fill_data_q <= fill_data_d;
      fill_word_q <= fill_word_d;
      mem_din_q <= mem_din_d;
    end
  end
  assign req_ready = (state_q == IDLE) && !rst;
  assign busy = state_q != IDLE;
  assign done = (state_q == DONE) && !fill_valid_q;
  assign fill_valid = fill_valid_q;
  assign fill_data = fill_data_q;
  assign fill_word = fill_word_q;
  assign wb_req = state_q == WB_REQ;
  assign wb_word = widx_q;
  assign mem_ren = state_q == RD;
  assign mem_wen = state_q == WR;
  assign mem_addr = {base_q, widx_q, 2'b00};
  assign mem_din = mem_din_q;
endmodule

// File: tb/tb_line_fill_engine.sv
// tb_line_fill_engine: scoreboard bench for fill/writeback timing, data and reset behaviour
module tb_line_fill_engine;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  typedef struct {int cyc; logic [31:0] a; logic [31:0] d;} exp_t;
  logic clk, rst;
  logic req_valid, req_ready, req_op, fill_valid, wb_req, busy, done, mem_ren, mem_wen;
  logic [31:0] req_addr, fill_data, wb_data, mem_addr, mem_din, mem_dout;
  logic [4:0] fill_word, wb_word;
  logic req_valid_1, req_ready_1, req_op_1, fill_valid_1, wb_req_1, busy_1, done_1, mem_ren_1, mem_wen_1;
  logic [31:0] req_addr_1, fill_data_1, mem_addr_1, unused_din_1, mem_dout_1;
  logic [4:0] fill_word_1, unused_wbw_1;
  int cyc = 0, pass_cnt = 0, total_cnt = 0, wen_len = 0;
  logic ren_p = 0, wen_p = 0;
  logic [31:0] addr_p = 0;
  exp_t fill_q[$], wr_q[$], fq1[$];
  logic [31:0] rda_q[$];
  int done_q[$], dq1[$];

  line_fill_engine #(.MEM_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .fill_valid(fill_valid), .fill_data(fill_data), .fill_word(fill_word),
    .wb_req(wb_req), .wb_word(wb_word), .wb_data(wb_data), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );
  line_fill_engine #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_ready(req_ready_1), .req_op(req_op_1),
    .req_addr(req_addr_1), .fill_valid(fill_valid_1), .fill_data(fill_data_1), .fill_word(fill_word_1),
    .wb_req(wb_req_1), .wb_word(unused_wbw_1), .wb_data(32'h0), .busy(busy_1), .done(done_1),
    .mem_ren(mem_ren_1), .mem_wen(mem_wen_1), .mem_addr(mem_addr_1), .mem_din(unused_din_1), .mem_dout(mem_dout_1)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_dout = 32'hA000_0000 + {27'd0, mem_addr[6:2]};
  assign mem_dout_1 = 32'hA000_0000 + {27'd0, mem_addr_1[6:2]};
  always @(posedge clk) wb_data <= 32'h5500_0000 + {27'd0, wb_word};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  task automatic fail(input string nm);
    total_cnt++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  task automatic push_fill(input int a, input logic [31:0] addr);
    logic [4:0] s, w;
    logic [31:0] base;
    s = CWF ? addr[6:2] : 5'd0;
    base = addr & ~32'h7F;
    for (int k = 0; k < 32; k++) begin
      w = s + 5'(k);
      fill_q.push_back('{a + 4 * (k + 1), {27'd0, w}, 32'hA000_0000 + {27'd0, w}});
      rda_q.push_back(base + {25'd0, w, 2'b00});
    end
    done_q.push_back(a + 129);
  endtask
  task automatic push_wb(input int b, input logic [31:0] addr);
    for (int k = 0; k < 32; k++)
      wr_q.push_back('{b + 6 * k + 2, (addr & ~32'h7F) + 32'(4 * k), 32'h5500_0000 + 32'(k)});
    done_q.push_back(b + 192);
  endtask
  task automatic drain();
    int n = 0;
    while ((fill_q.size() + wr_q.size() + rda_q.size() + done_q.size() + fq1.size() + dq1.size()) != 0 || busy || busy_1) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin
        fail("drain_timeout");
        break;
      end
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (mem_ren && mem_wen) fail("ren_wen_both");
    if (fill_valid) begin
      if (fill_q.size() == 0) fail("fill_unexpected");
      else begin
        e = fill_q.pop_front();
        chk("fill_cycle", cyc, e.cyc);
        chk("fill_word", {27'd0, fill_word}, e.a);
        chk("fill_data", fill_data, e.d);
      end
    end
    if (mem_ren && (!ren_p || mem_addr != addr_p)) begin
      if (rda_q.size() == 0) fail("read_unexpected");
      else chk("rd_addr", mem_addr, rda_q.pop_front());
    end
    if (mem_wen && !wen_p) begin
      if (wr_q.size() == 0) fail("write_unexpected");
      else begin
        e = wr_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_din, e.d);
      end
    end
    if (mem_wen) wen_len++;
    else if (wen_p) begin
      chk("wen_len", wen_len, 4);
      wen_len = 0;
    end
    if (done) begin
      chk("done_vs_ready", {31'd0, req_ready}, 0);
      if (done_q.size() == 0) fail("done_unexpected");
      else chk("done_cycle", cyc, done_q.pop_front());
    end
    ren_p = mem_ren;
    wen_p = mem_wen;
    addr_p = mem_addr;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (mem_ren_1 && mem_wen_1) fail("lat1_ren_wen_both");
    if (wb_req_1) fail("lat1_wb_req");
    if (fill_valid_1) begin
      if (fq1.size() == 0) fail("lat1_fill_unexpected");
      else begin
        e = fq1.pop_front();
        chk("lat1_fill_cycle", cyc, e.cyc);
        chk("lat1_fill_word", {27'd0, fill_word_1}, e.a);
        chk("lat1_fill_data", fill_data_1, e.d);
      end
    end
    if (done_1) begin
      if (dq1.size() == 0) fail("lat1_done_unexpected");
      else chk("lat1_done_cycle", cyc, dq1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, b, rc;
    rst = 1; req_valid = 0; req_op = 0; req_addr = 0;
    req_valid_1 = 0; req_op_1 = 0; req_addr_1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_fill_valid", {31'd0, fill_valid}, 0);
    chk("rst_ren", {31'd0, mem_ren}, 0);
    chk("rst_wen", {31'd0, mem_wen}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 1);
    chk("idle_ready_lat1", {31'd0, req_ready_1}, 1);
    a = cyc + 1;
    b = a + 131;
    push_fill(a, 32'h0000_1200);
    push_wb(b, 32'h0000_3380);
    req_valid = 1; req_op = 0; req_addr = 32'h0000_1200;
    @(negedge clk);
    chk("fill_accept_busy", {31'd0, busy}, 1);
    req_op = 1; req_addr = 32'h0000_3380;
    while (cyc < a + 129) @(negedge clk);
    chk("held_ready_in_done", {31'd0, req_ready}, 0);
    @(negedge clk);
    chk("ready_after_done", {31'd0, req_ready}, 1);
    @(negedge clk);
    chk("wb_accept_busy", {31'd0, busy}, 1);
    req_valid = 0;
    drain();
    a = cyc + 1;
    push_fill(a, 32'h0000_1274);
    req_valid = 1; req_op = 0; req_addr = 32'h0000_1274;
    @(negedge clk);
    req_valid = 0;
    drain();
    a = cyc + 1;
    push_fill(a, 32'h0000_1200);
    req_valid = 1; req_op = 0; req_addr = 32'h0000_1200;
    @(negedge clk);
    req_valid = 0;
    while (cyc < a + 44) @(negedge clk);
    rst = 1;
    @(negedge clk);
    fill_q.delete(); rda_q.delete(); done_q.delete();
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_ren", {31'd0, mem_ren}, 0);
    chk("midrst_fill_valid", {31'd0, fill_valid}, 0);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 0);
    a = cyc + 1;
    push_fill(a, 32'h0000_1200);
    req_valid = 1; req_op = 0; req_addr = 32'h0000_1200;
    @(negedge clk);
    req_valid = 0;
    drain();
    a = cyc + 1;
    for (int k = 0; k < 32; k++) fq1.push_back('{a + k + 1, 32'(k), 32'hA000_0000 + 32'(k)});
    dq1.push_back(a + 33);
    req_valid_1 = 1; req_op_1 = 0; req_addr_1 = 32'h0000_1200;
    @(negedge clk);
    req_valid_1 = 0;
    rc = 0;
    for (int i = 0; i < 32; i++) begin
      rc += int'(mem_ren_1);
      @(negedge clk);
    end
    chk("lat1_ren_cycles", rc, 32);
    chk("lat1_ren_off", {31'd0, mem_ren_1}, 0);
    drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
